// File: rtl/bcd_display_mux.sv
// Two-digit common-anode 7-segment scanner for a packed BCD count, with input
// stability filter, per-frame double buffer and anode-off guard. Option: LEADING_ZERO_BLANK_EN.
module bcd_display_mux #(
   parameter int REFRESH_DIV = 1000,
   parameter int GUARD       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] count,
   output logic [1:0] an,
   output logic [6:0] seg,
   output logic       frame_tick
);

   localparam logic [15:0] LAST_CNT  = 16'(REFRESH_DIV - 1);
   localparam logic [15:0] GUARD_CNT = 16'(GUARD);

   logic [15:0] refresh_cnt;
   logic        digit_sel;
   logic [7:0]  s1, s2, cand, disp_buf;
   logic [3:0]  cur_nib;
   logic [6:0]  cur_seg;
   logic        in_guard, slot_end;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;  // invalid BCD shows a dash
      endcase
   endfunction

   always_comb begin
      in_guard = (refresh_cnt < GUARD_CNT);
      slot_end = (refresh_cnt == LAST_CNT);
      cur_nib  = digit_sel ? disp_buf[7:4] : disp_buf[3:0];
      cur_seg  = decode(cur_nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (digit_sel && (disp_buf[7:4] == 4'd0))
         cur_seg = 7'h7F;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit_sel   <= 1'b0;
         s1          <= 8'h00;
         s2          <= 8'h00;
         cand        <= 8'h00;
         disp_buf    <= 8'h00;
         an          <= 2'b11;
         seg         <= 7'h7F;
         frame_tick  <= 1'b0;
      end else begin
         s1 <= count;
         s2 <= s1;
         if (s1 == s2)
            cand <= s2;
         if (enable) begin
            // outputs come from the pre-update scan state: a guard slot always
            // separates one anode from the next, so both are never low together
            an         <= in_guard ? 2'b11 : (digit_sel ? 2'b01 : 2'b10);
            seg        <= in_guard ? 7'h7F : cur_seg;
            frame_tick <= slot_end && digit_sel;
            if (slot_end) begin
               refresh_cnt <= '0;
               digit_sel   <= ~digit_sel;
               if (digit_sel)
                  disp_buf <= cand;
            end else begin
               refresh_cnt <= refresh_cnt + 16'd1;
            end
         end else begin
            an         <= 2'b11;
            seg        <= 7'h7F;
            frame_tick <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Scoreboard bench for bcd_display_mux (REFRESH_DIV=8, GUARD=2) plus directed frame checks.
module tb_bcd_display_mux;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic [7:0] count;
   logic [1:0] an;
   logic [6:0] seg;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;

   bcd_display_mux #(.REFRESH_DIV(8), .GUARD(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .count(count),
      .an(an), .seg(seg), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] d, input logic tens);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
`ifdef LEADING_ZERO_BLANK_EN
      if (tens && d == 4'd0) return 7'h7F;
`else
      if (tens) return t[d];
`endif
      return t[d];
   endfunction

   // reference scan model; expected {an,seg,frame_tick} queued per clock
   logic [9:0] exp_q[$];
   logic [9:0] e, got_v;
   logic [7:0] m_s1, m_s2, m_cand, m_buf;
   logic       m_sel;
   int         m_cnt;

   always @(posedge clk) begin
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_cand = 0; m_buf = 0; m_sel = 0; m_cnt = 0;
         e = {2'b11, 7'h7F, 1'b0};
      end else begin
         if (m_s1 == m_s2) m_cand = m_s2;
         m_s2 = m_s1;
         m_s1 = count;
         if (enable) begin
            if (m_cnt < 2) e = {2'b11, 7'h7F, 1'b0};
            else if (m_sel) e = {2'b01, ref_seg(m_buf[7:4], 1'b1), 1'b0};
            else e = {2'b10, ref_seg(m_buf[3:0], 1'b0), 1'b0};
            e[0] = (m_cnt == 7) && m_sel;
            m_cnt++;
            if (m_cnt == 8) begin
               m_cnt = 0;
               if (m_sel) m_buf = m_cand;
               m_sel = ~m_sel;
            end
         end else begin
            e = {2'b11, 7'h7F, 1'b0};
         end
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         got_v = {an, seg, frame_tick};
         chk("scan", 16'(got_v), 16'(exp_q.pop_front()));
         chk("an_both_low", 16'(an == 2'b00), 16'd0);
      end
   end

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 40);
      if (!frame_tick) chk("tick_timeout", 16'd0, 16'd1);
   endtask

   logic       pend_en = 1'b0;
   logic [7:0] pend_val;

   // called on a frame_tick negedge; ends on the following one
   task automatic check_frame(input string tag, input logic [6:0] s_ones, input logic [6:0] s_tens);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 5) begin
            chk({tag, "_an_ones"}, 16'(an), 16'(2'b10));
            chk({tag, "_seg_ones"}, 16'(seg), 16'(s_ones));
         end
         if (k == 13) begin
            chk({tag, "_an_tens"}, 16'(an), 16'(2'b01));
            chk({tag, "_seg_tens"}, 16'(seg), 16'(s_tens));
         end
         if (k == 3 && pend_en) begin
            count   = pend_val;
            pend_en = 1'b0;
         end
      end
      chk({tag, "_tick"}, 16'(frame_tick), 16'd1);
   endtask

   initial begin
      int n;
      reset = 1'b1; enable = 1'b1; count = 8'h00;
      repeat (3) begin
         @(negedge clk);
         chk("rst_an", 16'(an), 16'(2'b11));
         chk("rst_seg", 16'(seg), 16'(7'h7F));
         chk("rst_tick", 16'(frame_tick), 16'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("guard_an", 16'(an), 16'(2'b11));
      @(negedge clk);
      chk("first_an", 16'(an), 16'(2'b10));
      chk("first_seg", 16'(seg), 16'(7'h40));

      count = 8'h37;
      wait_tick();
      wait_tick();
      check_frame("f37", 7'h78, 7'h30);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 40);
      chk("period", 16'(n), 16'd16);

      pend_val = 8'h42; pend_en = 1'b1;
      check_frame("f37_hold", 7'h78, 7'h30);
      check_frame("f42", 7'h24, 7'h19);

      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (an == 2'b10) chk("tog_ones", 16'(seg), 16'(7'h24));
         if (an == 2'b01) chk("tog_tens", 16'(seg), 16'(7'h19));
         count = (i % 2 == 0) ? 8'h11 : 8'h99;
      end

      count = 8'hA5;
      wait_tick();
      wait_tick();
      check_frame("fA5", 7'h12, 7'h3F);

      count = 8'h05;
      wait_tick();
      repeat (3) @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("dis_an", 16'(an), 16'(2'b11));
         chk("dis_seg", 16'(seg), 16'(7'h7F));
         chk("dis_tick", 16'(frame_tick), 16'd0);
      end
      enable = 1'b1;
      wait_tick();
`ifdef LEADING_ZERO_BLANK_EN
      check_frame("f05", 7'h12, 7'h7F);
`else
      check_frame("f05", 7'h12, 7'h40);
`endif
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
